// File: rtl/key_evt_pkg.sv
// Shared event encodings for the keyboard event scheduler and its consumers.
package key_evt_pkg;

  localparam logic [1:0] EVT_MAKE   = 2'd0;
  localparam logic [1:0] EVT_BREAK  = 2'd1;
  localparam logic [1:0] EVT_REPEAT = 2'd2;

  // Queued word is {type[1:0], code[8:0]}.
  localparam int unsigned EVT_W = 11;

  typedef enum logic [1:0] {
    RptIdle   = 2'd0,
    RptDelay  = 2'd1,
    RptRepeat = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through FIFO with level count; DEPTH must be a power of two.
module key_evt_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [PW:0]      level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      level_q;
  logic             push_ok, pop_ok;

  assign empty = (level_q == '0);
  assign full  = (level_q == (PW+1)'(DEPTH));
  assign level = level_q;
  assign rdata = mem[rd_ptr_q];

  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full queue still lands.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + (PW+1)'(1);
        2'b01:   level_q <= level_q - (PW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/key_event_scheduler.sv
// Turns decoder strobes into MAKE/BREAK events, adds typematic REPEATs for the last
// pressed key, and serves the ordered stream through a valid/ready FIFO.
module key_event_scheduler
  import key_evt_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned DELAY_CYCLES = 50_000_000,
  parameter int unsigned RATE_CYCLES  = 10_000_000,
  parameter int unsigned CNT_W        = 26,
  localparam int unsigned LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_valid,
  input  logic [8:0]    last_change,
  input  logic [511:0]  key_down,
  input  logic          repeat_en,
  input  logic          clear,
  output logic          evt_valid,
  output logic [1:0]    evt_type,
  output logic [8:0]    evt_code,
  input  logic          evt_ready,
  output logic [LW-1:0] fifo_level,
  output logic          overflow
);

  localparam logic [CNT_W-1:0] DelayLast = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RateLast  = CNT_W'(RATE_CYCLES - 1);

  rpt_state_e       state_q, state_d;
  logic [8:0]       trk_code_q, trk_code_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             pend_q, pend_d;
  logic             overflow_q, overflow_d;

  logic             dec_push, dec_make, dec_break, rep_req, rep_want, rep_room;
  logic [1:0]       dec_type;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [EVT_W-1:0] fifo_wdata, fifo_rdata;

  assign dec_push  = key_valid & ~clear;
  assign dec_type  = key_down[last_change] ? EVT_MAKE : EVT_BREAK;
  assign dec_make  = dec_push & key_down[last_change];
  assign dec_break = dec_push & ~key_down[last_change];

  always_comb begin
    state_d    = state_q;
    trk_code_d = trk_code_q;
    timer_d    = timer_q;
    rep_req    = 1'b0;
    if (dec_make) begin
      state_d    = RptDelay;
      trk_code_d = last_change;
      timer_d    = '0;
    end else if (state_q != RptIdle) begin
      if ((dec_break && last_change == trk_code_q) || !key_down[trk_code_q] || !repeat_en) begin
        state_d = RptIdle;
        timer_d = '0;
      end else if (state_q == RptDelay && timer_q == DelayLast) begin
        rep_req = 1'b1;
        state_d = RptRepeat;
        timer_d = '0;
      end else if (state_q == RptRepeat && timer_q == RateLast) begin
        rep_req = 1'b1;
        timer_d = '0;
      end else begin
        timer_d = timer_q + CNT_W'(1);
      end
    end
    if (clear) begin
      state_d    = RptIdle;
      trk_code_d = '0;
      timer_d    = '0;
      rep_req    = 1'b0;
    end
  end

  // A held-over REPEAT survives only while its key is still tracked and held.
  assign rep_want = rep_req | (pend_q & (state_d != RptIdle) & ~dec_make);
  // One slot stays reserved so REPEATs never crowd out MAKE/BREAK.
  assign rep_room = (fifo_level < LW'(FIFO_DEPTH - 1));

  always_comb begin
    fifo_push  = 1'b0;
    fifo_wdata = {EVT_REPEAT, trk_code_q};
    pend_d     = 1'b0;
    if (dec_push) begin
      fifo_push  = 1'b1;
      fifo_wdata = {dec_type, last_change};
      pend_d     = rep_want;
    end else if (rep_want && rep_room) begin
      fifo_push  = 1'b1;
    end
  end

  assign fifo_pop   = ~fifo_empty & evt_ready;
  assign overflow_d = clear ? 1'b0 : (overflow_q | (dec_push & fifo_full & ~fifo_pop));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RptIdle;
      trk_code_q <= '0;
      timer_q    <= '0;
      pend_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      trk_code_q <= trk_code_d;
      timer_q    <= timer_d;
      pend_q     <= pend_d;
      overflow_q <= overflow_d;
    end
  end

  key_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_type  = fifo_empty ? 2'd0 : fifo_rdata[10:9];
  assign evt_code  = fifo_empty ? 9'd0 : fifo_rdata[8:0];
  assign overflow  = overflow_q;

endmodule
